// File: rtl/data_sram_like_slave_pkg.sv
// data_sram_like_slave_pkg
//   Shared constants and types for the SRAM-like data-side slave:
//   transfer size encodings, bus widths and the response FIFO entry.
package data_sram_like_slave_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // SRAM-like transfer size encodings (carried on the bus, not checked here)
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

  // One buffered response: write flag plus data (0 for writes)
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
  } resp_t;

endpackage

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo
//   DEPTH-entry synchronous FIFO of response entries. Occupancy is tracked
//   by a count; pointers wrap naturally (DEPTH is a power of two). The head
//   entry is presented combinationally whenever the FIFO is non-empty.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   push, push_data      write an entry at the tail
//   pop                  drop the head entry (only when head_valid)
//   head_valid           FIFO holds at least one entry
//   head_data            entry at the head
module sram_like_resp_fifo
  import data_sram_like_slave_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  push,
  input  resp_t push_data,
  input  logic  pop,
  output logic  head_valid,
  output resp_t head_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic [PW:0]   count_next;
  resp_t         mem [DEPTH];

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + (PW+1)'(1);
    end else if (!push && pop) begin
      count_next = count_reg - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head_valid = (count_reg != '0);
  assign head_data  = mem[rd_ptr_reg];

endmodule

// File: rtl/data_sram_like_slave.sv
// data_sram_like_slave
//   Responder for the data-side SRAM-like bus. Accepts requests with
//   addr_ok, issues them in order to a single-port synchronous RAM (read
//   data one cycle after ram_en) and returns exactly one data_ok per
//   request, in order, after LATENCY extra wait cycles at the head.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   req, wr, size, wstrb, addr, wdata request side (size is informational)
//   addr_ok                          request accepted when req & addr_ok
//   data_ok, rdata                   one-cycle response strobe and data
//   ram_en, ram_we, ram_addr, ram_wdata, ram_rdata   backing RAM port
module data_sram_like_slave
  import data_sram_like_slave_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 0,
  parameter int RAM_AW  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic [STRB_W-1:0] ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int               CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEPTH);
  localparam logic [3:0]       LAT     = 4'(LATENCY);

  logic [CW-1:0]     cnt_reg;
  logic [CW-1:0]     cnt_next;
  logic              p_valid_reg;
  logic              p_wr_reg;
  logic [3:0]        wait_reg;
  logic [3:0]        wait_cur;
  logic [3:0]        wait_next;
  logic              data_ok_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic  accept;
  logic  fifo_valid;
  logic  fifo_push;
  logic  fifo_pop;
  logic  head_valid;
  logic  head_fresh;
  logic  resp_fire;
  resp_t fifo_head;
  resp_t p_entry;
  resp_t head_entry;

  // Size and the byte-offset / upper address bits are not used.
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:RAM_AW+2], addr[1:0]};

  // ---------------- request side ----------------
  assign addr_ok   = (cnt_reg != CNT_MAX);
  assign accept    = req & addr_ok;
  assign ram_en    = accept;
  assign ram_we    = (accept && wr) ? wstrb : '0;
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = wdata;

  // ---------------- response side ----------------
  // The RAM result of last cycle's access is available now. When the FIFO
  // is empty it becomes the head immediately (bypass), so an isolated
  // request with LATENCY=0 responds two cycles after acceptance.
  assign p_entry    = {p_wr_reg, (p_wr_reg ? '0 : ram_rdata)};
  assign head_valid = fifo_valid | p_valid_reg;
  assign head_fresh = p_valid_reg & ~fifo_valid;
  assign head_entry = fifo_valid ? fifo_head : p_entry;

  // A freshly arriving head starts its wait at LATENCY; any other head
  // uses the running counter (reloaded to LATENCY on every pop).
  assign wait_cur  = head_fresh ? LAT : wait_reg;
  assign resp_fire = head_valid & (wait_cur == 4'd0);
  assign fifo_pop  = resp_fire & fifo_valid;
  assign fifo_push = p_valid_reg & ~(resp_fire & head_fresh);

  always_comb begin
    wait_next = wait_reg;
    if (resp_fire) begin
      wait_next = LAT;
    end else if (head_valid && (wait_cur != 4'd0)) begin
      wait_next = wait_cur - 4'd1;
    end
  end

  // Outstanding count is released only when data_ok is actually driven,
  // so addr_ok rises the cycle after the strobe that frees a slot.
  always_comb begin
    cnt_next = cnt_reg;
    if (accept && !data_ok_reg) begin
      cnt_next = cnt_reg + CW'(1);
    end else if (!accept && data_ok_reg) begin
      cnt_next = cnt_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg     <= '0;
      p_valid_reg <= 1'b0;
      p_wr_reg    <= 1'b0;
      wait_reg    <= 4'd0;
      data_ok_reg <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      cnt_reg     <= cnt_next;
      p_valid_reg <= accept;
      p_wr_reg    <= wr;
      wait_reg    <= wait_next;
      data_ok_reg <= resp_fire;
      rdata_reg   <= resp_fire ? head_entry.data : '0;
    end
  end

  sram_like_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (p_entry),
    .pop       (fifo_pop),
    .head_valid(fifo_valid),
    .head_data (fifo_head)
  );

  assign data_ok = data_ok_reg;
  assign rdata   = rdata_reg;

endmodule

// File: tb/tb_data_sram_like_slave.sv
// tb_data_sram_like_slave
//   Two instances (LATENCY=0 and LATENCY=3, DEPTH=4) driven per cycle and
//   compared against a transaction-level model: each accepted request gets
//   a predicted response cycle max(T+2+LAT, previous+LAT+1) and its data
//   from a shadow memory updated in acceptance order.
module tb_data_sram_like_slave;

  localparam int DEPTH  = 4;
  localparam int RAM_AW = 16;
  localparam int NI     = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic              req_s      [NI];
  logic              wr_s       [NI];
  logic [1:0]        size_s     [NI];
  logic [3:0]        wstrb_s    [NI];
  logic [31:0]       addr_s     [NI];
  logic [31:0]       wdata_s    [NI];
  logic              addr_ok_s  [NI];
  logic              data_ok_s  [NI];
  logic [31:0]       rdata_s    [NI];
  logic              ram_en_s   [NI];
  logic [3:0]        ram_we_s   [NI];
  logic [RAM_AW-1:0] ram_addr_s [NI];
  logic [31:0]       ram_wdata_s[NI];

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h11223344;
    return 32'(i) * 32'h9E3779B1 + 32'h00001357;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    bit   [31:0] mem [64];
    bit          wrt [64];
    logic [31:0] rrd;

    data_sram_like_slave #(
      .DEPTH  (DEPTH),
      .LATENCY((gi == 0) ? 0 : 3),
      .RAM_AW (RAM_AW)
    ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .req      (req_s[gi]),
      .wr       (wr_s[gi]),
      .size     (size_s[gi]),
      .wstrb    (wstrb_s[gi]),
      .addr     (addr_s[gi]),
      .wdata    (wdata_s[gi]),
      .addr_ok  (addr_ok_s[gi]),
      .data_ok  (data_ok_s[gi]),
      .rdata    (rdata_s[gi]),
      .ram_en   (ram_en_s[gi]),
      .ram_we   (ram_we_s[gi]),
      .ram_addr (ram_addr_s[gi]),
      .ram_wdata(ram_wdata_s[gi]),
      .ram_rdata(rrd)
    );

    // Backing single-port RAM, read-first, one-cycle read latency.
    always @(posedge clk) begin
      if (ram_en_s[gi]) begin
        rrd <= wrt[ram_addr_s[gi][5:0]] ? mem[ram_addr_s[gi][5:0]]
                                        : init_word(int'(ram_addr_s[gi][5:0]));
        if (ram_we_s[gi] != 4'b0) begin
          mem[ram_addr_s[gi][5:0]] <= merge_bytes(
              wrt[ram_addr_s[gi][5:0]] ? mem[ram_addr_s[gi][5:0]]
                                       : init_word(int'(ram_addr_s[gi][5:0])),
              ram_wdata_s[gi], ram_we_s[gi]);
          wrt[ram_addr_s[gi][5:0]] <= 1'b1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] shadow  [NI][64];
  int          exp_cyc [NI][64];
  logic [31:0] exp_dat [NI][64];
  int          qh      [NI];
  int          qt      [NI];
  int          outst   [NI];
  int          last_rc [NI];
  int          cyc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      qh[i] = 0; qt[i] = 0; outst[i] = 0; last_rc[i] = -100;
    end
  endtask

  task automatic set_in(input int i, input logic rq, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    req_s[i] = rq; wr_s[i] = w; addr_s[i] = a; wdata_s[i] = d; wstrb_s[i] = be;
    size_s[i] = 2'd2;
  endtask

  task automatic idle();
    for (int i = 0; i < NI; i++) set_in(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("%s i%0d data_ok", tag, i), 32'(data_ok_s[i]), 32'd0);
      check_val($sformatf("%s i%0d rdata", tag, i), rdata_s[i], 32'd0);
      check_val($sformatf("%s i%0d addr_ok", tag, i), 32'(addr_ok_s[i]), 32'd1);
    end
  endtask

  // Called at a negedge with inputs already applied; checks this cycle and
  // advances the model, returning at the next negedge.
  task automatic run_cycle();
    #1;
    for (int i = 0; i < NI; i++) begin
      logic        exp_ok, exp_acc, exp_dok;
      int          lat, rc, w;
      lat = (i == 0) ? 0 : 3;
      exp_ok  = (outst[i] != DEPTH);
      exp_dok = (qt[i] != qh[i]) && (exp_cyc[i][qh[i] % 64] == cyc);
      check_val($sformatf("i%0d addr_ok", i), 32'(addr_ok_s[i]), 32'(exp_ok));
      check_val($sformatf("i%0d data_ok", i), 32'(data_ok_s[i]), 32'(exp_dok));
      if (exp_dok) begin
        check_val($sformatf("i%0d rdata", i), rdata_s[i], exp_dat[i][qh[i] % 64]);
        $display("i%0d resp cycle %0d rdata=%h", i, cyc, rdata_s[i]);
      end
      exp_acc = req_s[i] & exp_ok;
      check_val($sformatf("i%0d ram_en", i), 32'(ram_en_s[i]), 32'(exp_acc));
      if (exp_acc) begin
        w = int'(addr_s[i][7:2]);
        check_val($sformatf("i%0d ram_addr", i), 32'(ram_addr_s[i]), 32'(addr_s[i][RAM_AW+1:2]));
        check_val($sformatf("i%0d ram_we", i), 32'(ram_we_s[i]), 32'(wr_s[i] ? wstrb_s[i] : 4'h0));
        check_val($sformatf("i%0d ram_wdata", i), ram_wdata_s[i], wdata_s[i]);
        rc = cyc + 2 + lat;
        if (last_rc[i] + lat + 1 > rc) rc = last_rc[i] + lat + 1;
        last_rc[i] = rc;
        exp_cyc[i][qt[i] % 64] = rc;
        exp_dat[i][qt[i] % 64] = wr_s[i] ? 32'h0 : shadow[i][w];
        qt[i]++;
        outst[i]++;
        if (wr_s[i]) shadow[i][w] = merge_bytes(shadow[i][w], wdata_s[i], wstrb_s[i]);
        $display("i%0d accept cycle %0d wr=%0d addr=%h", i, cyc, wr_s[i], addr_s[i]);
      end else begin
        check_val($sformatf("i%0d ram_we idle", i), 32'(ram_we_s[i]), 32'd0);
      end
      if (exp_dok) begin
        qh[i]++;
        outst[i]--;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 64; k++) shadow[i][k] = init_word(k);
    model_reset();
    cyc = 0;
    idle();
    resetn = 1'b1;
    #3 resetn = 1'b0;
    #1 check_reset("reset");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Isolated read of word 0x10
    set_in(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0); run_cycle();
    idle(); repeat (4) run_cycle();

    // Partial write then read of the same word
    set_in(0, 1'b1, 1'b1, 32'h40, 32'hAAAABBBB, 4'b0011); run_cycle();
    set_in(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0); run_cycle();
    idle(); repeat (4) run_cycle();

    // LATENCY=3 instance: req held for 6 cycles, fills to DEPTH
    for (int k = 0; k < 6; k++) begin
      set_in(1, 1'b1, 1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'h0); run_cycle();
    end
    idle(); repeat (25) run_cycle();

    // LATENCY=0 instance: 8 back-to-back reads
    for (int k = 0; k < 8; k++) begin
      set_in(0, 1'b1, 1'b0, 32'h80 + 32'(4 * k), 32'h0, 4'h0); run_cycle();
    end
    idle(); repeat (6) run_cycle();

    // Three reads in flight, then asynchronous reset mid-cycle
    for (int k = 0; k < 3; k++) begin
      set_in(0, 1'b1, 1'b0, 32'(4 * k), 32'h0, 4'h0);
      set_in(1, 1'b1, 1'b0, 32'(4 * k), 32'h0, 4'h0);
      run_cycle();
    end
    idle();
    #2 resetn = 1'b0;
    #1 check_reset("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) run_cycle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) begin
        set_in(i, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
               $urandom, 4'($urandom_range(0, 15)));
        size_s[i] = 2'($urandom_range(0, 2));
      end
      run_cycle();
    end
    idle(); repeat (40) run_cycle();
    for (int i = 0; i < NI; i++)
      check_val($sformatf("i%0d drained", i), 32'(qt[i] - qh[i]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
